// File: rtl/gpio_apb_arb24_pkg.sv
`default_nettype none
// ---- gpio_arb_pkg24 : shared types/constants for the GPIO APB arbiter ---- rev 1.0
package gpio_arb_pkg24;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Values the APB bus rests at whenever no transfer is on it
  localparam logic        IDLE_PSEL    = 1'b0;
  localparam logic        IDLE_PENABLE = 1'b0;
  localparam logic        IDLE_PWRITE  = 1'b0;
  localparam logic [31:0] IDLE_PWDATA  = 32'h0;

endpackage
`default_nettype wire

// File: rtl/gpio_apb_arb24_if.sv
`default_nettype none
// ---- gpio_apb_arb24_if : requester command + APB bus bundle ---- rev 1.0
interface gpio_apb_arb24_if
  import gpio_arb_pkg24::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [1:0]        req24;
  logic [1:0]        we24;
  logic [ADDR_W-1:0] addr0_24;
  logic [ADDR_W-1:0] addr1_24;
  logic [DATA_W-1:0] wdata0_24;
  logic [DATA_W-1:0] wdata1_24;
  logic [1:0]        done24;
  logic [DATA_W-1:0] rdata24;
  logic              busy24;
  logic              psel24;
  logic              penable24;
  logic              pwrite24;
  logic [ADDR_W-1:0] paddr24;
  logic [31:0]       pwdata24;
  logic [31:0]       prdata24;

  // master: the arbiter (APB master side); slave: requesters plus the GPIO slave
  modport master (
    input  req24, we24, addr0_24, addr1_24, wdata0_24, wdata1_24, prdata24,
    output done24, rdata24, busy24, psel24, penable24, pwrite24, paddr24, pwdata24
  );
  modport slave (
    output req24, we24, addr0_24, addr1_24, wdata0_24, wdata1_24, prdata24,
    input  done24, rdata24, busy24, psel24, penable24, pwrite24, paddr24, pwdata24
  );
endinterface
`default_nettype wire

// File: rtl/gpio_apb_arb24_rr_arb2.sv
`default_nettype none
// ---- rr_arb2_24 : combinational 2-way round-robin picker ---- rev 1.0
module rr_arb2_24
  import gpio_arb_pkg24::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       upd_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  assign upd_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/gpio_apb_arb24.sv
`default_nettype none
// ---- gpio_apb_arb24 : APB master sharing one GPIO slave between two requesters ---- rev 1.0
module gpio_apb_arb24
  import gpio_arb_pkg24::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              pclk24,
  input  logic              p_reset24,
  gpio_apb_arb24_if.master  bus
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              busy_q, busy_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              unused_prdata;

  rr_arb2_24 u_arb (
    .req_i  (bus.req24),
    .last_i (last_q),
    .gnt_o  (gnt),
    .upd_o  (grant_en)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          state_d     = S_SETUP;
          win_d       = gnt[1];
          last_d      = gnt[1];
          cmd_we_d    = gnt[1] ? bus.we24[1] : bus.we24[0];
          cmd_addr_d  = gnt[1] ? bus.addr1_24 : bus.addr0_24;
          cmd_wdata_d = gnt[1] ? 32'(bus.wdata1_24) : 32'(bus.wdata0_24);
          psel_d      = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        // prdata is only meaningful here; the bus drops to idle during DONE
        state_d     = S_DONE;
        psel_d      = IDLE_PSEL;
        penable_d   = IDLE_PENABLE;
        cmd_we_d    = IDLE_PWRITE;
        cmd_addr_d  = '0;
        cmd_wdata_d = IDLE_PWDATA;
        done_d      = win_q ? 2'b10 : 2'b01;
        rdata_d     = cmd_we_q ? '0 : bus.prdata24[DATA_W-1:0];
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 2'b00;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk24) begin
    if (p_reset24) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cmd_we_q    <= IDLE_PWRITE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= IDLE_PWDATA;
      psel_q      <= IDLE_PSEL;
      penable_q   <= IDLE_PENABLE;
      busy_q      <= 1'b0;
      done_q      <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.done24    = done_q;
  assign bus.rdata24   = rdata_q;
  assign bus.busy24    = busy_q;
  assign bus.psel24    = psel_q;
  assign bus.penable24 = penable_q;
  assign bus.pwrite24  = cmd_we_q;
  assign bus.paddr24   = cmd_addr_q;
  assign bus.pwdata24  = cmd_wdata_q;

  assign unused_prdata = ^bus.prdata24[31:DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_gpio_apb_arb24.sv
`default_nettype none
// ---- tb_gpio_apb_arb24 : directed bench with a transaction-level reference model ---- rev 1.0
module tb_gpio_apb_arb24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_apb_arb24_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  gpio_apb_arb24 #(.ADDR_W(6), .DATA_W(16)) dut (
    .pclk24    (clk),
    .p_reset24 (rst),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, outputs derived from cycles since grant
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_g = 0;
  int          m_win = 0;
  bit          m_last = 1'b1;
  logic        m_we = 1'b0;
  logic [5:0]  m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [15:0] m_rd = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_act  = 1'b0;
      m_last = 1'b1;
    end else if (!m_act) begin
      if (bus.req24 != 2'b00) begin
        if (bus.req24 == 2'b11) m_win = m_last ? 0 : 1;
        else                    m_win = bus.req24[1] ? 1 : 0;
        m_last = (m_win == 1);
        m_act  = 1'b1;
        m_g    = cyc;
        m_we   = bus.we24[m_win];
        m_addr = (m_win == 1) ? bus.addr1_24 : bus.addr0_24;
        m_wd   = (m_win == 1) ? bus.wdata1_24 : bus.wdata0_24;
        m_rd   = 16'h0;
      end
    end else if (cyc - m_g == 2) begin
      m_rd = m_we ? 16'h0 : bus.prdata24[15:0];
    end else if (cyc - m_g == 3) begin
      m_act = 1'b0;
    end
  end

  logic [59:0] exp_vec;
  logic [59:0] act_vec;
  int          age;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      exp_vec = '0;
      if (m_act) begin
        age = cyc - m_g;
        if (age <= 1)
          exp_vec = {2'b00, 16'h0, 1'b1, 1'b1, (age == 1), m_we, m_addr, 16'h0, m_wd};
        else
          exp_vec = {2'(2'b01 << m_win), m_rd, 1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0};
      end
      act_vec = {bus.done24, bus.rdata24, bus.busy24, bus.psel24, bus.penable24,
                 bus.pwrite24, bus.paddr24, bus.pwdata24};
      check($sformatf("model_cyc%0d", cyc), 64'(act_vec), 64'(exp_vec));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int maxc, output logic [1:0] d);
    d = 2'b00;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (bus.done24 != 2'b00) begin
        d = bus.done24;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [1:0]  d;
  logic [7:0]  dseq;
  logic [23:0] aseq;
  int          nd;
  int          t1;
  int          t2;

  initial begin
    bus.req24 = 2'b11;  bus.we24 = 2'b00;
    bus.addr0_24 = 6'h11; bus.addr1_24 = 6'h22;
    bus.wdata0_24 = 16'h0; bus.wdata1_24 = 16'h0;
    bus.prdata24 = 32'hDEAD0001;

    // reset held 3 cycles with both requesting
    tick(); chk_en = 1'b1;
    tick(); tick();
    check("reset_outputs", {bus.done24, bus.rdata24, bus.busy24, bus.psel24, bus.penable24,
          bus.pwrite24, bus.paddr24, bus.pwdata24}, 64'h0);
    rst = 1'b0;
    wait_done(8, d);
    check("first_tie_winner", d, 2'b01);
    check("first_tie_rdata", bus.rdata24, 16'h0001);
    tick(); bus.req24 = 2'b10;
    wait_done(8, d);
    check("second_winner", d, 2'b10);
    tick(); bus.req24 = 2'b00;

    // single write from requester 0
    bus.we24 = 2'b01; bus.addr0_24 = 6'h04; bus.wdata0_24 = 16'hA5A5; bus.req24 = 2'b01;
    tick();
    check("wr_setup", {bus.busy24, bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24, bus.pwdata24},
          {1'b1, 1'b1, 1'b0, 1'b1, 6'h04, 32'h0000A5A5});
    tick();
    check("wr_access", {bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24, bus.pwdata24},
          {1'b1, 1'b1, 1'b1, 6'h04, 32'h0000A5A5});
    tick();
    check("wr_done", {bus.done24, bus.rdata24, bus.psel24, bus.busy24}, {2'b01, 16'h0, 1'b0, 1'b1});
    tick(); bus.req24 = 2'b00;
    check("wr_idle_busy", bus.busy24, 1'b0);

    // single read from requester 1
    bus.we24 = 2'b00; bus.addr1_24 = 6'h08; bus.prdata24 = 32'hFFFF1234; bus.req24 = 2'b10;
    tick();
    check("rd_setup", {bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24, bus.pwdata24},
          {1'b1, 1'b0, 1'b0, 6'h08, 32'h0});
    tick(); tick();
    check("rd_done", {bus.done24, bus.rdata24}, {2'b10, 16'h1234});
    tick(); bus.req24 = 2'b00;

    // contention: both held for 16 cycles
    bus.we24 = 2'b01; bus.addr0_24 = 6'h10; bus.wdata0_24 = 16'h1111;
    bus.addr1_24 = 6'h20; bus.wdata1_24 = 16'h2222; bus.prdata24 = 32'hABCD5678;
    bus.req24 = 2'b11;
    nd = 0; dseq = '0; aseq = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.done24 != 2'b00) begin
        nd++;
        dseq = {dseq[5:0], bus.done24};
      end
      if (bus.psel24 && !bus.penable24) aseq = {aseq[17:0], bus.paddr24};
    end
    bus.req24 = 2'b00;
    check("cont_done_count", nd, 4);
    check("cont_done_seq", dseq, 8'b01_10_01_10);
    check("cont_addr_seq", aseq, {6'h10, 6'h20, 6'h10, 6'h20});

    // reset during ACCESS abandons the transfer
    bus.we24 = 2'b01; bus.addr0_24 = 6'h3F; bus.wdata0_24 = 16'hFFFF; bus.req24 = 2'b01;
    tick(); tick();
    check("pre_rst_access", {bus.psel24, bus.penable24}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.req24 = 2'b00;
    check("rst_mid_outputs", {bus.psel24, bus.penable24, bus.done24, bus.busy24, bus.paddr24}, 64'h0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done24 != 2'b00) nd++;
    end
    check("rst_no_done", nd, 0);
    bus.we24 = 2'b00; bus.addr1_24 = 6'h2A; bus.prdata24 = 32'h00009ABC; bus.req24 = 2'b10;
    wait_done(8, d);
    check("post_rst_done", {d, bus.rdata24}, {2'b10, 16'h9ABC});
    tick(); bus.req24 = 2'b00;

    // back-to-back from requester 0, req held through done
    bus.we24 = 2'b00; bus.addr0_24 = 6'h05; bus.prdata24 = 32'h55550F0F; bus.req24 = 2'b01;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done24 != 2'b00) begin
        check("b2b_done", {bus.done24, bus.rdata24}, {2'b01, 16'h0F0F});
        if (t1 < 0) t1 = i;
        else        t2 = i;
      end
      if (t2 >= 0) break;
    end
    tick(); bus.req24 = 2'b00;
    check("b2b_gap", t2 - t1, 4);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_apb_arb24.md
# gpio_apb_arb24

APB master and two-way round-robin arbiter that shares the single APB slave port of the GPIO lite block between two on-chip requesters, such as the CPU bridge and the power-management sequencer. Each requester issues simple register read/write commands with a req/done handshake. The block serialises these commands into APB Rev2 setup/access transfers, latches the slave's read data, and returns it to the requester that issued the command.

## Interface
Parameters:
- ADDR_W, 6, APB register address width.
- DATA_W, 16, GPIO data width; upper pwdata bits driven 0, upper prdata bits ignored.

Ports:
- pclk24  in  1  single clock; all state changes on rising edge.
- p_reset24  in  1  reset, synchronous, active-high.
- req24  in  2  per-requester command request, bit n = requester n.
- we24  in  2  per-requester write (1) / read (0).
- addr0_24, addr1_24  in  ADDR_W each  per-requester register address.
- wdata0_24, wdata1_24  in  DATA_W each  per-requester write data.
- done24  out  2  one-cycle completion pulse, one-hot.
- rdata24  out  DATA_W  read data, valid while done24 is nonzero.
- busy24  out  1  transfer in progress (state ≠ IDLE).
- psel24  out  1  APB select.
- penable24  out  1  APB enable.
- pwrite24  out  1  APB write.
- paddr24  out  ADDR_W  APB address.
- pwdata24  out  32  APB write data; bits 31:DATA_W are 0.
- prdata24  in  32  APB read data.

## Operation
- FSM states: IDLE → SETUP → ACCESS → DONE → IDLE. Every transfer takes exactly 4 cycles, with no wait states; the slave has no pready.
- IDLE:
  - If any req24 bit is set, arbitrate, latch the winner's we, addr and wdata into command registers, record the winner index, and go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration is round-robin on a 1-bit last-grant pointer:
  - A single requester wins unconditionally.
  - If both request, the requester ≠ last-grant wins.
  - The pointer updates to the winner at grant.
  - After reset the pointer is 1, so requester 0 wins the first tie.
- SETUP: psel24=1, penable24=0. pwrite24, paddr24 and pwdata24 are taken from the command registers.
- ACCESS: psel24=1, penable24=1, with the same pwrite24, paddr24 and pwdata24. On a read, prdata24[DATA_W-1:0] is captured into rdata24 at the end of ACCESS.
- DONE:
  - done24[winner]=1 for exactly this cycle; the APB bus is idle (psel24=0).
  - On a write, rdata24 is 0.
- Handshake:
  - A requester holds req and its command fields stable from assertion until it sees done.
  - A req still high in the cycle after done is a new command.
  - Command fields of a non-granted requester are never sampled.
- req changes after grant have no effect on the current transfer.
- Dropping req before done is not permitted; the transfer still completes and done still pulses.
- APB bus-idle values: psel24=0, penable24=0, pwrite24=0, paddr24=0, pwdata24=0.

## Timing
- Reset value of all outputs is 0: done24, rdata24, busy24, psel24, penable24, pwrite24, paddr24, pwdata24. Reset also sets the FSM to IDLE and the last-grant pointer to 1.
- Reset mid-transfer (any state): outputs go to 0 on the next edge, the transfer is abandoned, and no done pulse is issued.
- All outputs are registered; no input-to-output combinational path exists.
- Latency: req sampled high in IDLE at cycle t gives SETUP at t+1, ACCESS at t+2, and done at t+3.
- Minimum request-to-request period is 4 cycles.
- With both requesters continuously requesting, grants alternate 0,1,0,1… with one done every 4 cycles.
- busy24=1 in SETUP, ACCESS and DONE.

## Structure
- Package gpio_arb_pkg24 holds:
  - the state typedef (IDLE, SETUP, ACCESS, DONE), 2-bit encoding;
  - ADDR_W and DATA_W defaults;
  - the bus-idle constants.
- Sub-module rr_arb2_24 is a combinational 2-way round-robin picker (inputs: req[1:0], last; output: one-hot gnt[1:0]) plus the pointer update enable. The FSM, command registers and APB drive stay in the top module.

## Test plan
- Reset: hold p_reset24 for 3 cycles with req24=2'b11 → all outputs 0; first grant after release is requester 0.
- Single write: req24=2'b01, we=1, addr0=6'h04, wdata0=16'hA5A5 → SETUP at t+1 with psel=1, penable=0, paddr=6'h04, pwdata=32'h0000A5A5; ACCESS at t+2; done24=2'b01 at t+3; rdata24=0.
- Single read: req24=2'b10, we=0, addr1=6'h08, prdata24=32'hFFFF1234 during ACCESS → done24=2'b10 and rdata24=16'h1234 at t+3.
- Contention: req24=2'b11 held for 16 cycles → done24 sequence 01,10,01,10 at 4-cycle spacing; each APB transfer carries the granted requester's address.
- Reset in ACCESS: assert p_reset24 during ACCESS → next cycle psel=0, penable=0; no done pulse; a fresh request afterwards completes normally.
- Back-to-back same requester: req0 held high through done → new grant in the following IDLE; a second done appears 4 cycles after the first.
